// File: rtl/vram_arbiter.sv
// Two-port arbiter (video fetch over CPU window) onto one async 8-bit SRAM.
// Latency: done ACCESS_CYCLES edges after grant; requests are level-held and answered by a one-cycle done.
module vram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned MAX_VID_RUN   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] vid_addr,
    input  logic        vid_req,
    output logic [7:0]  vid_data,
    output logic        vid_done,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_di,
    input  logic        cpu_rw,
    input  logic        cpu_req,
    output logic [7:0]  cpu_do,
    output logic        cpu_done,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    input  logic [7:0]  sram_din,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_VID_RUN);

    state_t      state_q, state_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic [3:0]  run_q, run_d;
    logic        gnt_cpu_q, gnt_cpu_d;
    logic        rd_q, rd_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic [7:0]  cpu_do_q, cpu_do_d;
    logic        vid_done_q, vid_done_d;
    logic        cpu_done_q, cpu_done_d;
    logic        pick_cpu;
    logic        pick_rd;

    // CPU wins only when it is alone or the video run has hit its limit.
    assign pick_cpu = cpu_req && (!vid_req || (run_q == RUN_MAX));
    assign pick_rd  = !pick_cpu || cpu_rw;

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        run_d      = run_q;
        gnt_cpu_d  = gnt_cpu_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        vid_data_d = vid_data_q;
        cpu_do_d   = cpu_do_q;
        vid_done_d = 1'b0;
        cpu_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (vid_req || cpu_req) begin
                    addr_d    = pick_cpu ? cpu_addr : vid_addr;
                    ce_n_d    = 1'b0;
                    rd_d      = pick_rd;
                    gnt_cpu_d = pick_cpu;
                    acc_cnt_d = ACC_LOAD;
                    state_d   = ACCESS;
                    if (pick_rd) begin
                        oe_n_d = 1'b0;
                    end else begin
                        dout_d  = cpu_di;
                        dq_oe_d = 1'b1;
                        we_n_d  = 1'b0;
                    end
                    if (pick_cpu || !cpu_req) begin
                        run_d = 4'd0;
                    end else if (run_q != RUN_MAX) begin
                        run_d = run_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                if (acc_cnt_q == 4'd0) begin
                    if (rd_q) begin
                        if (gnt_cpu_q) begin
                            cpu_do_d = sram_din;
                        end else begin
                            vid_data_d = sram_din;
                        end
                    end
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    we_n_d     = 1'b1;
                    cpu_done_d = gnt_cpu_q;
                    vid_done_d = !gnt_cpu_q;
                    state_d    = HOLD;
                end else begin
                    acc_cnt_d = acc_cnt_q - 4'd1;
                end
            end
            HOLD: begin
                // Address and data are still driven here for hold time after the strobes rise.
                dq_oe_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_cnt_q  <= 4'd0;
            run_q      <= 4'd0;
            gnt_cpu_q  <= 1'b0;
            rd_q       <= 1'b1;
            addr_q     <= 16'h0000;
            dout_q     <= 8'h00;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            vid_data_q <= 8'h00;
            cpu_do_q   <= 8'h00;
            vid_done_q <= 1'b0;
            cpu_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            run_q      <= run_d;
            gnt_cpu_q  <= gnt_cpu_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            vid_data_q <= vid_data_d;
            cpu_do_q   <= cpu_do_d;
            vid_done_q <= vid_done_d;
            cpu_done_q <= cpu_done_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_dout  = dout_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign vid_data   = vid_data_q;
    assign cpu_do     = cpu_do_q;
    assign vid_done   = vid_done_q;
    assign cpu_done   = cpu_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: three instances (ACCESS_CYCLES 2, 1, 5) each with a behavioural SRAM.
// Completions are scored against a per-instance queue of expected (port, data) entries.
module tb_vram_arbiter;

    localparam int N       = 3;
    localparam int MAX_RUN = 4;

    typedef struct {
        bit         cpu;
        logic [7:0] data;
    } exp_t;

    function automatic int ac_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    // Contents of never-written SRAM locations.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h7C;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vid_addr   [N];
    logic        vid_req    [N];
    logic [7:0]  vid_data   [N];
    logic        vid_done   [N];
    logic [15:0] cpu_addr   [N];
    logic [7:0]  cpu_di     [N];
    logic        cpu_rw     [N];
    logic        cpu_req    [N];
    logic [7:0]  cpu_do     [N];
    logic        cpu_done   [N];
    logic [15:0] sram_addr  [N];
    logic [7:0]  sram_dout  [N];
    logic [7:0]  sram_din   [N];
    logic        sram_dq_oe [N];
    logic        sram_ce_n  [N];
    logic        sram_oe_n  [N];
    logic        sram_we_n  [N];

    exp_t exp_q [N][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [7:0] mem     [65536];
        bit         written [65536];

        vram_arbiter #(
            .ACCESS_CYCLES(ac_of(g)),
            .MAX_VID_RUN  (MAX_RUN)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .vid_addr  (vid_addr[g]),
            .vid_req   (vid_req[g]),
            .vid_data  (vid_data[g]),
            .vid_done  (vid_done[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_di    (cpu_di[g]),
            .cpu_rw    (cpu_rw[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_do    (cpu_do[g]),
            .cpu_done  (cpu_done[g]),
            .sram_addr (sram_addr[g]),
            .sram_dout (sram_dout[g]),
            .sram_din  (sram_din[g]),
            .sram_dq_oe(sram_dq_oe[g]),
            .sram_ce_n (sram_ce_n[g]),
            .sram_oe_n (sram_oe_n[g]),
            .sram_we_n (sram_we_n[g])
        );

        assign sram_din[g] = (!sram_ce_n[g] && !sram_oe_n[g]) ?
                             (written[sram_addr[g]] ? mem[sram_addr[g]] : pat(sram_addr[g])) : 8'h00;

        always @(posedge clk) begin
            if (!rst && !sram_ce_n[g] && !sram_we_n[g] && sram_dq_oe[g]) begin
                mem[sram_addr[g]]     <= sram_dout[g];
                written[sram_addr[g]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input int k, input bit cpu, input logic [7:0] d);
        exp_t e;
        chk("done_has_expectation", 32'(exp_q[k].size() != 0), 32'd1);
        if (exp_q[k].size() != 0) begin
            e = exp_q[k].pop_front();
            chk("done_port", 32'(cpu), 32'(e.cpu));
            chk("done_data", 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (vid_done[k]) check_done(k, 1'b0, vid_data[k]);
                if (cpu_done[k]) check_done(k, 1'b1, cpu_do[k]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sweep(input int k, input logic [15:0] a);
        int ac;
        int width;
        int t1;
        int t2;
        ac    = ac_of(k);
        width = 0;
        t1    = -1;
        t2    = -1;
        exp_q[k].push_back('{cpu: 1'b0, data: pat(a)});
        exp_q[k].push_back('{cpu: 1'b0, data: pat(a)});
        vid_addr[k] = a;
        vid_req[k]  = 1'b1;
        for (int i = 1; i <= 40 && t2 < 0; i++) begin
            step(1);
            if (t1 < 0 && !sram_ce_n[k] && !sram_oe_n[k]) width++;
            if (vid_done[k]) begin
                if (t1 < 0) begin
                    t1 = i;
                end else begin
                    t2 = i;
                    vid_req[k] = 1'b0;
                end
            end
        end
        vid_req[k] = 1'b0;
        chk($sformatf("sweep%0d_latency", ac), t1, ac + 1);
        chk($sformatf("sweep%0d_strobe_width", ac), width, ac);
        chk($sformatf("sweep%0d_period", ac), t2 - t1, ac + 2);
    endtask

    initial begin
        int n_cpu;
        int n_low;
        int found;

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            vid_addr[k] = 16'h0000;
            vid_req[k]  = 1'b0;
            cpu_addr[k] = 16'h0000;
            cpu_di[k]   = 8'h00;
            cpu_rw[k]   = 1'b1;
            cpu_req[k]  = 1'b0;
        end
        step(2);
        chk("rst_ce_n", sram_ce_n[0], 1);
        chk("rst_oe_n", sram_oe_n[0], 1);
        chk("rst_we_n", sram_we_n[0], 1);
        chk("rst_dq_oe", sram_dq_oe[0], 0);
        chk("rst_addr", sram_addr[0], 0);
        chk("rst_dout", sram_dout[0], 0);
        chk("rst_vid_data", vid_data[0], 0);
        chk("rst_cpu_do", cpu_do[0], 0);
        chk("rst_dones", {vid_done[0], cpu_done[0]}, 0);
        rst = 1'b0;
        step(2);
        chk("idle_ce_n", sram_ce_n[0], 1);

        // Reset in the middle of a CPU write: strobes drop at once and no done appears.
        cpu_addr[0] = 16'h4000;
        cpu_di[0]   = 8'h11;
        cpu_rw[0]   = 1'b0;
        cpu_req[0]  = 1'b1;
        step(1);
        chk("abort_we_n_active", sram_we_n[0], 0);
        chk("abort_dq_oe_active", sram_dq_oe[0], 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_we_n", sram_we_n[0], 1);
        chk("abort_ce_n", sram_ce_n[0], 1);
        chk("abort_dq_oe", sram_dq_oe[0], 0);
        chk("abort_cpu_done", cpu_done[0], 0);
        cpu_req[0] = 1'b0;
        cpu_rw[0]  = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk("post_abort_ce_n", sram_ce_n[0], 1);
        chk("post_abort_addr", sram_addr[0], 0);
        chk("post_abort_dout", sram_dout[0], 0);
        chk("post_abort_cpu_done", cpu_done[0], 0);

        // Video read at 0x1234.
        exp_q[0].push_back('{cpu: 1'b0, data: 8'h5A});
        vid_addr[0] = 16'h1234;
        vid_req[0]  = 1'b1;
        step(1);
        chk("vrd_ce_n_c1", sram_ce_n[0], 0);
        chk("vrd_oe_n_c1", sram_oe_n[0], 0);
        chk("vrd_we_n_c1", sram_we_n[0], 1);
        chk("vrd_addr_c1", sram_addr[0], 16'h1234);
        chk("vrd_done_c1", vid_done[0], 0);
        step(1);
        chk("vrd_ce_n_c2", sram_ce_n[0], 0);
        chk("vrd_done_c2", vid_done[0], 0);
        step(1);
        chk("vrd_done_c3", vid_done[0], 1);
        chk("vrd_ce_n_c3", sram_ce_n[0], 1);
        chk("vrd_oe_n_c3", sram_oe_n[0], 1);
        chk("vrd_addr_hold", sram_addr[0], 16'h1234);
        vid_req[0] = 1'b0;
        step(1);
        chk("vrd_done_c4", vid_done[0], 0);
        chk("vrd_addr_c4", sram_addr[0], 16'h1234);
        chk("vrd_data_held", vid_data[0], 8'h5A);

        // CPU write 0xA5 to 0x8000, then read it back.
        exp_q[0].push_back('{cpu: 1'b1, data: 8'h00});
        cpu_addr[0] = 16'h8000;
        cpu_di[0]   = 8'hA5;
        cpu_rw[0]   = 1'b0;
        cpu_req[0]  = 1'b1;
        step(1);
        chk("cwr_we_n_c1", sram_we_n[0], 0);
        chk("cwr_oe_n_c1", sram_oe_n[0], 1);
        chk("cwr_dq_oe_c1", sram_dq_oe[0], 1);
        chk("cwr_dout_c1", sram_dout[0], 8'hA5);
        step(1);
        chk("cwr_we_n_c2", sram_we_n[0], 0);
        step(1);
        chk("cwr_done", cpu_done[0], 1);
        chk("cwr_we_n_c3", sram_we_n[0], 1);
        chk("cwr_dout_hold", sram_dout[0], 8'hA5);
        chk("cwr_cpu_do_kept", cpu_do[0], 8'h00);
        cpu_req[0] = 1'b0;
        cpu_rw[0]  = 1'b1;
        step(1);
        chk("cwr_dq_oe_released", sram_dq_oe[0], 0);
        exp_q[0].push_back('{cpu: 1'b1, data: 8'hA5});
        cpu_req[0] = 1'b1;
        step(3);
        chk("crd_done", cpu_done[0], 1);
        chk("crd_readback", cpu_do[0], 8'hA5);
        chk("crd_vid_data_kept", vid_data[0], 8'h5A);
        cpu_req[0] = 1'b0;
        step(2);

        // Both requesters held: four video slots, then the CPU, twice over.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < MAX_RUN; i++) exp_q[0].push_back('{cpu: 1'b0, data: pat(16'h1000)});
            exp_q[0].push_back('{cpu: 1'b1, data: pat(16'h0042)});
        end
        vid_addr[0] = 16'h1000;
        cpu_addr[0] = 16'h0042;
        vid_req[0]  = 1'b1;
        cpu_req[0]  = 1'b1;
        n_cpu = 0;
        for (int t = 0; t < 200 && n_cpu < 2; t++) begin
            step(1);
            if (cpu_done[0]) n_cpu++;
        end
        vid_req[0] = 1'b0;
        cpu_req[0] = 1'b0;
        chk("fair_cpu_slots", n_cpu, 2);
        step(4);
        chk("fair_queue_drained", exp_q[0].size(), 0);

        // Requester drops req one cycle after done: no second grant.
        exp_q[0].push_back('{cpu: 1'b0, data: pat(16'hFFFF)});
        vid_addr[0] = 16'hFFFF;
        vid_req[0]  = 1'b1;
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            step(1);
            if (vid_done[0]) found = 1;
        end
        chk("late_drop_done_seen", found, 1);
        step(1);
        vid_req[0] = 1'b0;
        n_low = 0;
        for (int t = 0; t < 8; t++) begin
            step(1);
            if (!sram_ce_n[0]) n_low++;
        end
        chk("late_drop_no_regrant", n_low, 0);
        chk("late_drop_queue", exp_q[0].size(), 0);

        sweep(0, 16'h0100);
        sweep(1, 16'hFFFF);
        sweep(2, 16'h7777);
        step(3);
        for (int k = 0; k < N; k++) chk($sformatf("final_queue%0d", k), exp_q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

endmodule
